// File: rtl/motor_drive_nch.sv
// rtl/motor_drive_nch.sv - N-channel DC motor drive core
// Ramped signed speed per channel, shared-counter PWM into a TB6612-style bridge, windowed encoder speed.
module motor_drive_nch #(
  parameter int N_CH      = 2,
  parameter int CMD_W     = 8,
  parameter int PWM_W     = 14,
  parameter int TICK_DIV  = 15625,
  parameter int RAMP_STEP = 1,
  parameter int CNT_W     = 16,
  parameter int FB_WIN    = 1250000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    brk,
  input  logic [N_CH*CMD_W-1:0]   cmd,
  input  logic                    cmd_valid,
  input  logic [N_CH-1:0]         fb,
  output logic [N_CH-1:0]         pwm,
  output logic [N_CH-1:0]         in1,
  output logic [N_CH-1:0]         in2,
  output logic                    stnby,
  output logic [N_CH-1:0]         ramp_busy,
  output logic [N_CH*CNT_W-1:0]   fb_count,
  output logic [N_CH*CNT_W-1:0]   fb_speed,
  output logic                    fb_valid
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WIN_W  = (FB_WIN > 1) ? $clog2(FB_WIN) : 1;
  localparam int SHIFT  = PWM_W - CMD_W + 1;
  localparam logic [CMD_W-1:0] CMD_NEG_FS  = {1'b1, {(CMD_W-1){1'b0}}};
  localparam logic [CMD_W-1:0] CMD_NEG_SAT = CMD_NEG_FS + 1'b1;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [WIN_W-1:0]  win_cnt;
  logic              win_end;
  logic [PWM_W-1:0]  pwm_cnt;

  logic [CMD_W-1:0]  target    [N_CH];
  logic [CMD_W-1:0]  level     [N_CH];
  logic [CMD_W-1:0]  level_nxt [N_CH];
  logic [CMD_W-1:0]  mag       [N_CH];
  logic [PWM_W-1:0]  duty      [N_CH];
  logic [N_CH-1:0]   dead;
  logic [N_CH-1:0]   dead_nxt;

  logic [N_CH-1:0]   fb_s1, fb_s2, fb_s3, fb_rise;
  logic [CNT_W-1:0]  acc     [N_CH];
  logic [CNT_W-1:0]  acc_nxt [N_CH];

  assign tick    = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign win_end = (win_cnt == WIN_W'(FB_WIN - 1));
  assign fb_rise = fb_s2 & ~fb_s3;

  // One ramp step; a level of opposite sign to its target only decays toward zero.
  function automatic logic [CMD_W-1:0] ramp_next(input logic signed [CMD_W-1:0] lv,
                                                 input logic signed [CMD_W-1:0] tg,
                                                 input logic                    hold);
    int l, t, r;
    l = int'(lv);
    t = int'(tg);
    r = l;
    if (l == 0) begin
      if (!hold) begin
        if (t > 0)      r = (t < RAMP_STEP) ? t : RAMP_STEP;
        else if (t < 0) r = (-t < RAMP_STEP) ? t : -RAMP_STEP;
      end
    end else if (((l > 0) == (t > 0)) || (t == 0)) begin
      if (t > l) r = (t - l < RAMP_STEP) ? t : l + RAMP_STEP;
      else       r = (l - t < RAMP_STEP) ? t : l - RAMP_STEP;
    end else begin
      if (l > 0) r = (l < RAMP_STEP) ? 0 : l - RAMP_STEP;
      else       r = (-l < RAMP_STEP) ? 0 : l + RAMP_STEP;
    end
    return CMD_W'(r);
  endfunction

  // dead marks a level that just arrived at zero; the next tick is spent holding there.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      level_nxt[i] = ramp_next(level[i], target[i], dead[i]);
      dead_nxt[i]  = dead[i];
      if (level[i] == '0)
        dead_nxt[i] = 1'b0;
      else if (level_nxt[i] == '0)
        dead_nxt[i] = 1'b1;
      mag[i]     = level[i][CMD_W-1] ? (~level[i] + 1'b1) : level[i];
      duty[i]    = PWM_W'(mag[i]) << SHIFT;
      acc_nxt[i] = (&acc[i]) ? acc[i] : acc[i] + CNT_W'(fb_rise[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt  <= '0;
      win_cnt   <= '0;
      pwm_cnt   <= '0;
      fb_s1     <= '0;
      fb_s2     <= '0;
      fb_s3     <= '0;
      dead      <= '0;
      pwm       <= '0;
      in1       <= '0;
      in2       <= '0;
      stnby     <= 1'b0;
      ramp_busy <= '0;
      fb_count  <= '0;
      fb_speed  <= '0;
      fb_valid  <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        target[i] <= '0;
        level[i]  <= '0;
        acc[i]    <= '0;
      end
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      win_cnt  <= win_end ? '0 : win_cnt + 1'b1;
      pwm_cnt  <= pwm_cnt + 1'b1;
      stnby    <= enable;
      fb_valid <= win_end;
      fb_s1    <= fb;
      fb_s2    <= fb_s1;
      fb_s3    <= fb_s2;
      for (int i = 0; i < N_CH; i++) begin
        if (brk)
          target[i] <= '0;
        else if (cmd_valid)
          target[i] <= (cmd[i*CMD_W +: CMD_W] == CMD_NEG_FS) ? CMD_NEG_SAT : cmd[i*CMD_W +: CMD_W];

        if (brk || !enable) begin
          level[i] <= '0;
          dead[i]  <= 1'b0;
        end else if (tick) begin
          level[i] <= level_nxt[i];
          dead[i]  <= dead_nxt[i];
        end

        ramp_busy[i] <= (level[i] != target[i]);
        // Brake shorts the bridge regardless of standby.
        pwm[i] <= brk | (enable & (pwm_cnt < duty[i]));
        in1[i] <= brk | (enable & ~level[i][CMD_W-1] & (level[i] != '0));
        in2[i] <= brk | (enable & level[i][CMD_W-1]);

        fb_count[i*CNT_W +: CNT_W] <= fb_count[i*CNT_W +: CNT_W] + CNT_W'(fb_rise[i]);
        if (win_end) begin
          fb_speed[i*CNT_W +: CNT_W] <= acc_nxt[i];
          acc[i]                     <= '0;
        end else begin
          acc[i] <= acc_nxt[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_motor_drive_nch.sv
// tb/tb_motor_drive_nch.sv - scoreboard bench for motor_drive_nch against an integer reference model
module tb_motor_drive_nch;

  localparam int N_CH      = 2;
  localparam int CMD_W     = 8;
  localparam int PWM_W     = 8;
  localparam int TICK_DIV  = 4;
  localparam int RAMP_STEP = 4;
  localparam int CNT_W     = 5;
  localparam int FB_WIN    = 100;
  localparam int VW        = 4*N_CH + 2 + N_CH*CNT_W;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int LVL_MAX   = (1 << (CMD_W-1)) - 1;

  logic                  clk = 1'b0;
  logic                  rst, enable, brk, cmd_valid;
  logic [N_CH*CMD_W-1:0] cmd;
  logic [N_CH-1:0]       fb;
  logic [N_CH-1:0]       pwm, in1, in2, ramp_busy;
  logic                  stnby, fb_valid;
  logic [N_CH*CNT_W-1:0] fb_count, fb_speed;

  motor_drive_nch #(
    .N_CH(N_CH), .CMD_W(CMD_W), .PWM_W(PWM_W), .TICK_DIV(TICK_DIV),
    .RAMP_STEP(RAMP_STEP), .CNT_W(CNT_W), .FB_WIN(FB_WIN)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .brk(brk), .cmd(cmd), .cmd_valid(cmd_valid),
    .fb(fb), .pwm(pwm), .in1(in1), .in2(in2), .stnby(stnby), .ramp_busy(ramp_busy),
    .fb_count(fb_count), .fb_speed(fb_speed), .fb_valid(fb_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit done  = 1'b0;

  logic [VW-1:0]         exp_q[$];
  logic [N_CH*CNT_W-1:0] spd_q[$];

  int m_t[N_CH], m_l[N_CH], m_arr[N_CH], m_cnt[N_CH], m_acc[N_CH];
  int m_n;
  bit m_hist[N_CH][3];

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int ramp_ref(input int lv, input int tg, input bit may_leave);
    if (lv == 0) return may_leave ? sgn(tg) * imin(RAMP_STEP, iabs(tg)) : 0;
    if (lv * tg < 0) return sgn(lv) * imax(iabs(lv) - RAMP_STEP, 0);
    return lv + sgn(tg - lv) * imin(RAMP_STEP, iabs(tg - lv));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict the outputs produced by the coming clock edge from the inputs now driven.
  task automatic model_step();
    logic [N_CH-1:0]       e_pwm, e_in1, e_in2, e_busy;
    logic [N_CH*CNT_W-1:0] e_cnt, e_spd;
    bit tick, win;
    int tick_no, c, rise, nl;
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        m_t[i] = 0; m_l[i] = 0; m_arr[i] = -10; m_cnt[i] = 0; m_acc[i] = 0;
        for (int j = 0; j < 3; j++) m_hist[i][j] = 1'b0;
      end
      m_n = 0;
      exp_q.push_back('0);
      return;
    end
    m_n++;
    tick    = (m_n % TICK_DIV) == 0;
    tick_no = m_n / TICK_DIV;
    win     = (m_n % FB_WIN) == 0;
    e_spd   = '0;
    for (int i = 0; i < N_CH; i++) begin
      e_pwm[i]  = brk || (enable && (((m_n - 1) % (1 << PWM_W)) < iabs(m_l[i]) * (1 << (PWM_W - CMD_W + 1))));
      e_in1[i]  = brk || (enable && m_l[i] > 0);
      e_in2[i]  = brk || (enable && m_l[i] < 0);
      e_busy[i] = (m_l[i] != m_t[i]);
      rise      = (m_hist[i][1] && !m_hist[i][2]) ? 1 : 0;
      m_cnt[i]  = (m_cnt[i] + rise) % (1 << CNT_W);
      e_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
      if (win) begin
        e_spd[i*CNT_W +: CNT_W] = CNT_W'(imin(m_acc[i] + rise, CNT_MAX));
        m_acc[i] = 0;
      end else begin
        m_acc[i] = imin(m_acc[i] + rise, CNT_MAX);
      end
      m_hist[i][2] = m_hist[i][1];
      m_hist[i][1] = m_hist[i][0];
      m_hist[i][0] = fb[i];
      if (brk || !enable) begin
        m_l[i]   = 0;
        m_arr[i] = -10;
      end else if (tick) begin
        nl = ramp_ref(m_l[i], m_t[i], tick_no >= m_arr[i] + 2);
        if (m_l[i] != 0 && nl == 0) m_arr[i] = tick_no;
        m_l[i] = nl;
      end
      c = int'($signed(cmd[i*CMD_W +: CMD_W]));
      if (brk)            m_t[i] = 0;
      else if (cmd_valid) m_t[i] = (c < -LVL_MAX) ? -LVL_MAX : c;
    end
    exp_q.push_back({e_pwm, e_in1, e_in2, enable, e_busy, win, e_cnt});
    if (win) spd_q.push_back(e_spd);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic send_cmd(input int c0, input int c1);
    cmd       = {CMD_W'(c1), CMD_W'(c0)};
    cmd_valid = 1'b1;
    run(1);
    cmd_valid = 1'b0;
  endtask

  task automatic duty_of(input int ch, output int hi);
    hi = 0;
    for (int k = 0; k < (1 << PWM_W); k++) begin
      run(1);
      hi += int'(pwm[ch]);
    end
  endtask

  task automatic fb_pulses(input int ch, input int n, input int hi, input int lo);
    for (int k = 0; k < n; k++) begin
      fb[ch] = 1'b1;
      run(hi);
      fb[ch] = 1'b0;
      run(lo);
    end
  endtask

  // Monitor: every edge consumes one predicted vector; each fb_valid consumes one speed record.
  initial begin
    logic [VW-1:0] e, a;
    logic [N_CH*CNT_W-1:0] s;
    forever begin
      @(posedge clk);
      #1;
      a = {pwm, in1, in2, stnby, ramp_busy, fb_valid, fb_count};
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("outputs", int'(a), int'(e));
      end else if (!done) begin
        check("outputs_queue", int'(a), -1);
      end
      if (fb_valid && !done) begin
        if (spd_q.size() != 0) begin
          s = spd_q.pop_front();
          check("fb_speed", int'(fb_speed), int'(s));
        end else begin
          check("fb_speed_queue", int'(fb_speed), -1);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, brk_left, en_left;
    rst = 1'b1; enable = 1'b1; brk = 1'b0; cmd = '0; cmd_valid = 1'b0; fb = '0;
    run(3);
    check("reset_outputs", int'({pwm, in1, in2, stnby, ramp_busy, fb_valid, fb_count, fb_speed}), 0);
    rst = 1'b0;

    send_cmd(64, 0);
    run(80);
    check("ramp_busy_done", int'(ramp_busy[0]), 0);
    check("ramp_dir", int'({in1[0], in2[0]}), 2);
    duty_of(0, hi);
    check("duty_plus64", hi, 128);

    send_cmd(8, 0);
    run(80);
    send_cmd(-8, 0);
    run(40);
    check("reverse_dir", int'({in1[0], in2[0]}), 1);

    send_cmd(64, 64);
    run(80);
    brk = 1'b1;
    run(1);
    check("brake_in1", int'(in1), 3);
    check("brake_in2", int'(in2), 3);
    check("brake_pwm", int'(pwm), 3);
    send_cmd(100, -100);
    run(4);
    brk = 1'b0;
    run(20);
    check("coast_after_brake", int'({in1, in2, pwm, ramp_busy}), 0);

    send_cmd(-128, 0);
    run(150);
    duty_of(0, hi);
    check("duty_neg_fs", hi, 254);
    duty_of(1, hi);
    check("duty_zero", hi, 0);

    enable = 1'b0;
    run(3);
    check("standby", int'({stnby, pwm, in1, in2}), 0);
    enable = 1'b1;
    run(5);
    check("target_kept", int'(ramp_busy[0]), 1);
    run(200);

    rst = 1'b1;
    run(1);
    rst = 1'b0;
    fb_pulses(1, 7, 2, 2);
    run(80);
    check("fb_count_ch1", int'(fb_count[CNT_W +: CNT_W]), 7);
    check("fb_speed_ch1", int'(fb_speed[CNT_W +: CNT_W]), 7);
    fb_pulses(0, 31, 1, 1);
    run(4);
    check("fb_count_full", int'(fb_count[0 +: CNT_W]), CNT_MAX);
    fb_pulses(0, 1, 1, 1);
    run(4);
    check("fb_count_wrap", int'(fb_count[0 +: CNT_W]), 0);

    rst = 1'b1;
    run(1);
    rst = 1'b0;
    for (int k = 0; k < 110; k++) begin
      fb[0] = ~fb[0];
      run(1);
    end
    check("fb_speed_sat", int'(fb_speed[0 +: CNT_W]), CNT_MAX);

    send_cmd(40, -40);
    for (int k = 0; k < 30; k++) begin
      fb = fb ^ 2'b11;
      run(1);
    end
    rst = 1'b1;
    run(1);
    check("midrun_reset", int'({pwm, in1, in2, stnby, ramp_busy, fb_valid, fb_count, fb_speed}), 0);
    rst = 1'b0;

    brk_left = 0;
    en_left  = 0;
    for (int k = 0; k < 2500; k++) begin
      rst = ($urandom_range(0, 499) == 0);
      if (brk_left > 0) begin
        brk = 1'b1;
        brk_left--;
      end else begin
        brk = 1'b0;
        if ($urandom_range(0, 149) == 0) brk_left = $urandom_range(1, 8);
      end
      if (en_left > 0) begin
        enable = 1'b0;
        en_left--;
      end else begin
        enable = 1'b1;
        if ($urandom_range(0, 299) == 0) en_left = $urandom_range(1, 12);
      end
      cmd_valid = ($urandom_range(0, 24) == 0);
      if (cmd_valid) begin
        for (int i = 0; i < N_CH; i++) begin
          case ($urandom_range(0, 3))
            0:       cmd[i*CMD_W +: CMD_W] = 8'h80;
            1:       cmd[i*CMD_W +: CMD_W] = CMD_W'($urandom_range(0, 16) - 8);
            default: cmd[i*CMD_W +: CMD_W] = CMD_W'($urandom);
          endcase
        end
      end
      for (int i = 0; i < N_CH; i++)
        if ($urandom_range(0, 2) == 0) fb[i] = ~fb[i];
      run(1);
    end
    rst = 1'b0;
    cmd_valid = 1'b0;

    done = 1'b1;
    if (exp_q.size() != 0) check("leftover_vectors", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
